// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
// The completer side is expected to adopt this package as well.
package apb_pkg;

  localparam int unsigned APB_ADDR_W_DEF = 32;
  localparam int unsigned APB_DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'b00,
    APB_SETUP  = 2'b01,
    APB_ACCESS = 2'b10
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS wait-state counter. expired_o pulses on the wait cycle whose
// increment would bring the count up to limit_i.
module apb_timeout_ctr
  import apb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       inc_i,
  input  logic [7:0] limit_i,
  output logic       expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o = inc_i && (cnt_q == limit_i - 8'd1);

endmodule

// File: rtl/apb_master.sv
// APB requester: one local command at a time through IDLE->SETUP->ACCESS.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W_DEF,
  parameter int unsigned DATA_W         = APB_DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be in 1..255");
  end

  apb_state_t        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              expired;
  logic              abort;

  assign cmd_ready = (state_q == APB_IDLE) || ((state_q == APB_ACCESS) && PREADY);
  assign abort     = (state_q == APB_ACCESS) && !PREADY && expired;

`ifdef APB_TIMEOUT_EN
  logic rsp_err_q;

  apb_timeout_ctr u_timeout_ctr (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clear_i  (state_q == APB_SETUP),
    .inc_i    ((state_q == APB_ACCESS) && !PREADY),
    .limit_i  (8'(TIMEOUT_CYCLES)),
    .expired_o(expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET)
      rsp_err_q <= 1'b0;
    else
      rsp_err_q <= abort;
  end

  assign rsp_err = rsp_err_q;
`else
  assign expired = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      APB_IDLE: begin
        if (cmd_valid) begin
          state_d   = APB_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
        end
      end
      APB_SETUP: begin
        state_d   = APB_ACCESS;
        penable_d = 1'b1;
      end
      APB_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          // A command accepted on the completion edge skips IDLE; PSEL stays high.
          if (cmd_valid) begin
            state_d   = APB_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            paddr_d   = cmd_addr;
            pwrite_d  = cmd_write;
            pwdata_d  = cmd_wdata;
          end else begin
            state_d   = APB_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else if (abort) begin
          state_d     = APB_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d   = APB_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= APB_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed plus randomized transfers against a transaction-level expectation
// of the APB requester; honours APB_TIMEOUT_EN when defined.
module tb_apb_master;

  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam int MAXW = TO - 1;
`else
  localparam int MAXW = 5;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic        rsp_pend;
  logic [31:0] exp_rdata;
  logic        exp_err;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Response expected on this cycle, and the held read data otherwise.
  task automatic chk_rsp();
    chk("rsp_valid", 64'(rsp_valid), 64'(rsp_pend));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("rsp_err", 64'(rsp_err), 64'(rsp_pend ? exp_err : 1'b0));
    rsp_pend = 1'b0;
  endtask

  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
    chk_rsp();
  endtask

  task automatic chk_bus(input bit sel, input bit en, input logic [31:0] a,
                         input bit w, input logic [31:0] d);
    chk("PSEL", 64'(PSEL), 64'(sel));
    chk("PENABLE", 64'(PENABLE), 64'(en));
    if (sel) begin
      chk("PADDR", 64'(PADDR), 64'(a));
      chk("PWRITE", 64'(PWRITE), 64'(w));
      chk("PWDATA", 64'(PWDATA), 64'(d));
    end
  endtask

  task automatic present(input bit w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    #1 chk("cmd_ready_accept", 64'(cmd_ready), 64'(1));
  endtask

  // Runs one transfer whose command is presented for the coming edge.
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] rd,
                      input bit chain, input bit nw, input logic [31:0] na,
                      input logic [31:0] nd);
    step();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    chk_bus(1'b1, 1'b0, a, w, d);
    PREADY = 1'($urandom);
    #1 chk("cmd_ready_setup", 64'(cmd_ready), 64'(0));
    for (int i = 0; i <= waits; i++) begin
      step();
      chk_bus(1'b1, 1'b1, a, w, d);
      PREADY = (i == waits);
      PRDATA = (i == waits) ? rd : $urandom;
      if (i == waits && chain) begin
        present(nw, na, nd);
      end else begin
        cmd_valid = (i == waits) ? 1'b0 : 1'($urandom);
        cmd_addr  = $urandom;
        #1 chk("cmd_ready_access", 64'(cmd_ready), 64'(i == waits));
      end
    end
    rsp_pend  = 1'b1;
    exp_rdata = w ? 32'h0 : rd;
    exp_err   = 1'b0;
  endtask

  task automatic finish_idle();
    step();
    chk_bus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cmd_valid = 1'b0;
    PREADY    = 1'b0;
    #1 chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    bit          cw, nw, chain;
    logic [31:0] ca, cd, na, nd, rd;
    int          waits;

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; PREADY = 1'b0; PRDATA = '0;
    rsp_pend = 1'b0; exp_rdata = '0; exp_err = 1'b0;

    // Reset then idle
    repeat (3) begin
      step();
      chk_bus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("PADDR_rst", 64'(PADDR), 64'(0));
      chk("PWDATA_rst", 64'(PWDATA), 64'(0));
      chk("PWRITE_rst", 64'(PWRITE), 64'(0));
    end
    PRESET = 1'b0;
    #1 chk("cmd_ready_rst", 64'(cmd_ready), 64'(1));
    step();
    chk_bus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Zero-wait write
    present(1'b1, 32'h4, 32'hDEADBEEF);
    xfer(1'b1, 32'h4, 32'hDEADBEEF, 0, $urandom, 1'b0, 1'b0, 32'h0, 32'h0);
    finish_idle();

    // Read with 3 wait states, then response data must hold
    present(1'b0, 32'h4, 32'h1234_5678);
    xfer(1'b0, 32'h4, 32'h1234_5678, 3, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    finish_idle();
    step();
    step();

    // Back-to-back writes
    present(1'b1, 32'h1, 32'hAAAA_0001);
    xfer(1'b1, 32'h1, 32'hAAAA_0001, 0, 32'h0, 1'b1, 1'b1, 32'h2, 32'hBBBB_0002);
    xfer(1'b1, 32'h2, 32'hBBBB_0002, 0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    finish_idle();

    // Reset mid-ACCESS
    present(1'b0, 32'h8, 32'h0);
    step();
    cmd_valid = 1'b0;
    step();
    chk_bus(1'b1, 1'b1, 32'h8, 1'b0, 32'h0);
    PREADY = 1'b0; PRESET = 1'b1; exp_rdata = '0;
    step();
    chk_bus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    PRESET = 1'b0;
    present(1'b0, 32'hC, 32'h0);
    xfer(1'b0, 32'hC, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 32'h0);
    finish_idle();

    // Wait-state limit behaviour
    present(1'b0, 32'h10, 32'h0);
    step();
    cmd_valid = 1'b0; PREADY = 1'b0;
    chk_bus(1'b1, 1'b0, 32'h10, 1'b0, 32'h0);
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      step();
      chk_bus(1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
      #1 chk("cmd_ready_abort", 64'(cmd_ready), 64'(0));
    end
    rsp_pend = 1'b1; exp_rdata = '0; exp_err = 1'b1;
    step();
    chk_bus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1 chk("cmd_ready_after_abort", 64'(cmd_ready), 64'(1));
    // PREADY on the last allowed wait cycle completes normally
    present(1'b0, 32'h14, 32'h0);
    xfer(1'b0, 32'h14, 32'h0, TO - 1, 32'h5A5A_A5A5, 1'b0, 1'b0, 32'h0, 32'h0);
    finish_idle();
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk_bus(1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
    end
    PRESET = 1'b1; exp_rdata = '0;
    step();
    PRESET = 1'b0;
    chk_bus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
`endif

    // Randomized transfers, with random chaining and idle gaps
    cw = 1'($urandom); ca = $urandom; cd = $urandom;
    present(cw, ca, cd);
    for (int k = 0; k < 40; k++) begin
      nw = 1'($urandom); na = $urandom; nd = $urandom; rd = $urandom;
      waits = int'($urandom_range(0, MAXW));
      chain = (k < 39) && 1'($urandom);
      xfer(cw, ca, cd, waits, rd, chain, nw, na, nd);
      if (!chain) begin
        finish_idle();
        repeat ($urandom_range(0, 2)) begin
          step();
          chk_bus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        if (k < 39) present(nw, na, nd);
      end
      cw = nw; ca = na; cd = nd;
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
